// File: rtl/nn_dma_arb.sv
// Round-robin arbiter sharing one 16-bit DMA memory port between the host loader,
// the nn read channel and a FIFO-buffered nn write channel, with a read-after-write hazard check.
module nn_dma_arb #(
  parameter int DMA_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 16,
  parameter int WFIFO_DEPTH    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_host_req,
  input  logic                      i_host_we,
  input  logic [DMA_ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0]     i_host_wdata,
  output logic                      o_host_gnt,
  output logic [DATA_WIDTH-1:0]     o_host_rdata,
  output logic                      o_host_rvalid,
  input  logic                      i_nn_rd_en,
  input  logic [DMA_ADDR_WIDTH-1:0] i_nn_rd_addr,
  output logic [DATA_WIDTH-1:0]     o_nn_rd_data,
  output logic                      o_nn_rd_ready,
  input  logic                      i_nn_wr_en,
  input  logic [DMA_ADDR_WIDTH-1:0] i_nn_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_nn_wr_data,
  output logic                      o_wr_ovf,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [DMA_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);
  localparam int PW = $clog2(WFIFO_DEPTH);

  typedef enum logic [1:0] {SEL_H = 2'd0, SEL_R = 2'd1, SEL_W = 2'd2} sel_e;

  logic [DMA_ADDR_WIDTH-1:0] r_fa [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fd [WFIFO_DEPTH];
  logic [WFIFO_DEPTH-1:0]    r_vld;
  logic [PW-1:0]             r_wp, r_rp;
  logic [PW:0]               r_cnt;
  sel_e                      r_rr, w_rr_nxt;
  logic                      r_rd_busy, r_host_pend, r_ovf;
  logic [DATA_WIDTH-1:0]     r_nn_rdata, r_host_rdata;

  logic w_empty, w_full, w_hit;
  logic w_el_h, w_el_r, w_el_w;
  logic w_gnt_h, w_gnt_r, w_gnt_w;
  logic w_push, w_pop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (PW+1)'(WFIFO_DEPTH));

  // A read may not overtake any queued write to its address, including one arriving now.
  always_comb begin
    w_hit = i_nn_wr_en && (i_nn_wr_addr == i_nn_rd_addr);
    for (int i = 0; i < WFIFO_DEPTH; i++)
      if (r_vld[i] && (r_fa[i] == i_nn_rd_addr)) w_hit = 1'b1;
  end

  // r_rd_busy doubles as the ready flag: it is high exactly in the ready cycle.
  assign w_el_h = i_host_req;
  assign w_el_r = i_nn_rd_en && !r_rd_busy && !w_hit;
  assign w_el_w = !w_empty;

  always_comb begin
    w_gnt_h  = 1'b0;
    w_gnt_r  = 1'b0;
    w_gnt_w  = 1'b0;
    w_rr_nxt = r_rr;
    if (i_rst) begin
      if (w_full) w_gnt_w = 1'b1;
      else begin
        case (r_rr)
          SEL_H: begin
            if (w_el_h)      w_gnt_h = 1'b1;
            else if (w_el_r) w_gnt_r = 1'b1;
            else if (w_el_w) w_gnt_w = 1'b1;
          end
          SEL_R: begin
            if (w_el_r)      w_gnt_r = 1'b1;
            else if (w_el_w) w_gnt_w = 1'b1;
            else if (w_el_h) w_gnt_h = 1'b1;
          end
          default: begin
            if (w_el_w)      w_gnt_w = 1'b1;
            else if (w_el_h) w_gnt_h = 1'b1;
            else if (w_el_r) w_gnt_r = 1'b1;
          end
        endcase
      end
      if (w_gnt_h) w_rr_nxt = SEL_R;
      if (w_gnt_r) w_rr_nxt = SEL_W;
      if (w_gnt_w) w_rr_nxt = SEL_H;
    end
  end

  assign w_pop  = w_gnt_w;
  assign w_push = i_rst && i_nn_wr_en && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_vld        <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_rr         <= SEL_H;
      r_rd_busy    <= 1'b0;
      r_host_pend  <= 1'b0;
      r_ovf        <= 1'b0;
      r_nn_rdata   <= '0;
      r_host_rdata <= '0;
    end else begin
      // Pop clears before push sets, so a full push+pop on the same slot stays valid.
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      if (w_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + 1'b1;
      end
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (i_nn_wr_en && w_full && !w_pop) r_ovf <= 1'b1;
      r_rr        <= w_rr_nxt;
      r_rd_busy   <= w_gnt_r;
      r_host_pend <= w_gnt_h && !i_host_we;
      if (r_rd_busy)   r_nn_rdata   <= i_mem_rdata;
      if (r_host_pend) r_host_rdata <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fa[r_wp] <= i_nn_wr_addr;
      r_fd[r_wp] <= i_nn_wr_data;
    end
  end

  assign o_host_gnt    = w_gnt_h;
  assign o_host_rvalid = i_rst && r_host_pend;
  assign o_host_rdata  = !i_rst ? '0 : (r_host_pend ? i_mem_rdata : r_host_rdata);
  assign o_nn_rd_ready = i_rst && r_rd_busy;
  assign o_nn_rd_data  = !i_rst ? '0 : (r_rd_busy ? i_mem_rdata : r_nn_rdata);
  assign o_wr_ovf      = r_ovf;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt_h) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_host_we;
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_we ? i_host_wdata : '0;
    end else if (w_gnt_r) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_nn_rd_addr;
    end else if (w_gnt_w) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = r_fa[r_rp];
      o_mem_wdata = r_fd[r_rp];
    end
  end

endmodule
